// File: rtl/coin_conditioner.sv
// rtl/coin_conditioner.sv - debounced coin pushbuttons queued into one-cycle coin pulses
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   five_raw  raw bouncy 5-cent button
//   ten_raw   raw bouncy 10-cent button
//   ready     vending core accepts a coin pulse (sampled only in IDLE)
//   five      registered one-cycle 5-cent pulse
//   ten       registered one-cycle 10-cent pulse
//   pending   number of queued coin events
//   overflow  sticky: a coin event was dropped
module coin_conditioner #(
    parameter int DB_CYCLES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          five_raw,
    input  logic                          ten_raw,
    input  logic                          ready,
    output logic                          five,
    output logic                          ten,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0]    DB_LAST = 4'(DB_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Bit 0 carries the five button, bit 1 the ten button throughout.
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      db_q;
    logic [1:0]      db_d;
    logic [1:0]      db_prev_q;
    logic [1:0][3:0] cnt_q;
    logic [1:0][3:0] cnt_d;
    logic [1:0]      press;

    logic            mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            overflow_q;

    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic            head;

    state_t          state_q;
    logic            five_q;
    logic            ten_q;

    // Two-flop synchronizers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {ten_raw, five_raw};
            sync_q <= meta_q;
        end
    end

    // The counter only advances while the synchronized value disagrees with
    // the debounced level; any agreement restarts the qualification window.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q      <= 2'b00;
            db_prev_q <= 2'b00;
            cnt_q     <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // Press event lasts the single cycle after the debounced level rises.
    assign press = db_q & ~db_prev_q;

    // A ten press wins over a simultaneous five press.
    assign push_req = |press;
    assign full     = (count_q == FULL_COUNT);
    assign pop      = (state_q == IDLE) && (count_q != '0) && ready;
    assign push     = push_req && (!full || pop);
    assign drop     = (press[0] && press[1]) || (push_req && !push);
    assign head     = mem_q[rd_ptr_q];
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= press[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Output sequencer: PULSE and GAP are unconditional, so consecutive
    // pulses are always at least three cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            five_q  <= 1'b0;
            ten_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= PULSE;
                        five_q  <= ~head;
                        ten_q   <= head;
                    end
                end
                PULSE: begin
                    state_q <= GAP;
                    five_q  <= 1'b0;
                    ten_q   <= 1'b0;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    five_q  <= 1'b0;
                    ten_q   <= 1'b0;
                end
            endcase
        end
    end

    assign five     = five_q;
    assign ten      = ten_q;
    assign pending  = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_coin_conditioner.sv
// tb/tb_coin_conditioner.sv - self-checking bench for coin_conditioner
module tb_coin_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       five_raw;
    logic       ten_raw;
    logic       ready;
    logic       five;
    logic       ten;
    logic [2:0] pending;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int cyc         = 0;
    bit sb[$];
    int pulse_cyc[$];

    coin_conditioner #(.DB_CYCLES(DB), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .five_raw (five_raw),
        .ten_raw  (ten_raw),
        .ready    (ready),
        .five     (five),
        .ten      (ten),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard consumer: every observed pulse must match the oldest expected coin.
    always @(negedge clk) begin
        bit exp_coin;
        if (rst && (five || ten)) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            vectors++;
            if (five && ten) begin
                miscompares++;
                $display("FAIL both_high: five=%0b ten=%0b required one-hot", five, ten);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: five=%0b ten=%0b required none", five, ten);
            end else begin
                exp_coin = sb.pop_front();
                if (ten !== exp_coin) begin
                    miscompares++;
                    $display("FAIL coin_order: got ten=%0b required ten=%0b", ten, exp_coin);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // which: 0 = five, 1 = ten, 2 = both together
    task automatic press(input int which, input int hold, input int gap);
        @(posedge clk); #2;
        five_raw = (which != 1);
        ten_raw  = (which != 0);
        idle(hold);
        five_raw = 1'b0;
        ten_raw  = 1'b0;
        idle(gap);
    endtask

    task automatic test_reset;
        rst = 1'b0; five_raw = 1'b0; ten_raw = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vectors++; if (five !== 1'b0) begin miscompares++; $display("FAIL reset_five: got %0b required 0", five); end
        vectors++; if (ten !== 1'b0) begin miscompares++; $display("FAIL reset_ten: got %0b required 0", ten); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL reset_pending: got %0d required 0", pending); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
        @(posedge clk); #2;
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_clean_press;
        int first = 0;
        int p0;
        p0 = pulses;
        ready = 1'b1;
        sb.push_back(1'b0);
        @(posedge clk); #2;
        five_raw = 1'b1;
        for (int e = 1; e <= 40 && first == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == DB + 3) begin
                vectors++;
                if (pending !== 3'd1) begin miscompares++; $display("FAIL clean_push_pending: got %0d required 1", pending); end
            end
            if (five) first = e;
        end
        vectors++;
        if (first != DB + 4) begin miscompares++; $display("FAIL clean_latency: got edge %0d required %0d", first, DB + 4); end
        idle(20);
        five_raw = 1'b0;
        idle(15);
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL clean_pending: got %0d required 0", pending); end
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL clean_count: got %0d required 1", pulses - p0); end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulses;
        ready = 1'b1;
        sb.push_back(1'b1);
        @(posedge clk); #2;
        for (int i = 0; i < 10; i++) begin
            ten_raw = ~ten_raw;
            idle(1);
        end
        ten_raw = 1'b1;
        idle(20);
        ten_raw = 1'b0;
        idle(20);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL bounce_ten_count: got %0d required 1", pulses - p0); end
        p0 = pulses;
        press(0, 3, 20);
        vectors++; if (pulses - p0 != 0) begin miscompares++; $display("FAIL glitch_press: got %0d pulses required 0", pulses - p0); end
        // A short dropout while held must not produce a second press.
        sb.push_back(1'b0);
        five_raw = 1'b1;
        idle(15);
        five_raw = 1'b0;
        idle(3);
        five_raw = 1'b1;
        idle(12);
        five_raw = 1'b0;
        idle(15);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL glitch_release: got %0d pulses required 1", pulses - p0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL bounce_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        int p0;
        int n0;
        int t;
        p0 = pulses;
        ready = 1'b0;
        sb.push_back(1'b0); press(0, 8, 8);
        sb.push_back(1'b1); press(1, 8, 8);
        sb.push_back(1'b0); press(0, 8, 8);
        sb.push_back(1'b0); press(0, 8, 8);
        vectors++; if (pending !== 3'd4) begin miscompares++; $display("FAIL queue_pending: got %0d required 4", pending); end
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL queue_held: got %0d pulses required 0", pulses - p0); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL queue_no_overflow: got %0b required 0", overflow); end
        n0 = pulse_cyc.size();
        ready = 1'b1;
        t = 0;
        while (pulses - p0 < 4 && t < 40) begin idle(1); t++; end
        idle(3);
        vectors++; if (pulses - p0 != 4) begin miscompares++; $display("FAIL queue_count: got %0d required 4", pulses - p0); end
        for (int i = n0 + 1; i < pulse_cyc.size(); i++) begin
            vectors++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 3) begin
                miscompares++;
                $display("FAIL queue_spacing: got %0d cycles required 3", pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL queue_drain: got %0d required 0", pending); end
    endtask

    task automatic test_overflow;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(1'b0);
            press(0, 8, 8);
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_at_full: got %0b required 0", overflow); end
        press(0, 8, 8);
        vectors++; if (pending !== 3'd4) begin miscompares++; $display("FAIL ovf_pending: got %0d required 4", pending); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %0b required 1", overflow); end
        ready = 1'b1;
        idle(25);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL ovf_drain: got %0d left required 0", sb.size()); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %0b required 1", overflow); end
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        ready = 1'b0;
        idle(2);
        sb.push_back(1'b1);
        press(2, 8, 8);
        vectors++; if (pending !== 3'd1) begin miscompares++; $display("FAIL both_pending: got %0d required 1", pending); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL both_overflow: got %0b required 1", overflow); end
        ready = 1'b1;
        idle(10);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL both_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_pulse;
        int p0;
        int t;
        ready = 1'b0;
        sb.push_back(1'b0); press(0, 8, 8);
        sb.push_back(1'b1); press(1, 8, 8);
        sb.push_back(1'b0); press(0, 8, 8);
        vectors++; if (pending !== 3'd3) begin miscompares++; $display("FAIL mid_queued: got %0d required 3", pending); end
        ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(five || ten) && t < 20) begin @(negedge clk); t++; end
        vectors++; if (five !== 1'b1) begin miscompares++; $display("FAIL mid_in_pulse: got five=%0b required 1", five); end
        vectors++; if (pending !== 3'd2) begin miscompares++; $display("FAIL mid_pending: got %0d required 2", pending); end
        #1 rst = 1'b0;
        #1;
        vectors++; if (five !== 1'b0 || ten !== 1'b0) begin miscompares++; $display("FAIL mid_drop: got five=%0b ten=%0b required 0 0", five, ten); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL mid_clear_pending: got %0d required 0", pending); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_clear_overflow: got %0b required 0", overflow); end
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        p0 = pulses;
        idle(30);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL mid_silent: got %0d pulses required 0", pulses - p0); end
        // Button held through reset yields exactly one press once released.
        rst = 1'b0;
        five_raw = 1'b1;
        idle(2);
        sb.push_back(1'b0);
        rst = 1'b1;
        idle(20);
        five_raw = 1'b0;
        idle(15);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL held_through_reset: got %0d pulses required 1", pulses - p0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL held_drain: got %0d left required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_overflow();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive clk cycles a synchronized input must differ from its debounced value before that value changes (range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of queued coin events (fixed power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port five_raw  input  1  raw, asynchronous, bouncy 5-cent pushbutton.
REQ-006 SHALL have port ten_raw  input  1  raw, asynchronous, bouncy 10-cent pushbutton.
REQ-007 SHALL have port ready  input  1  downstream vending core can accept a coin pulse this cycle.
REQ-008 SHALL have port five  output  1  registered one-cycle 5-cent coin pulse to the vending core.
REQ-009 SHALL have port ten  output  1  registered one-cycle 10-cent coin pulse to the vending core.
REQ-010 SHALL have port pending  output  3  number of coin events currently queued (0..FIFO_DEPTH).
REQ-011 SHALL have port overflow  output  1  sticky flag: a coin event was dropped.

Function
REQ-012 SHALL pass each raw input through a two-flop synchronizer before any other use.
REQ-013 SHALL keep one debounce counter and one debounced level per input; counter clears whenever the synchronized value equals the debounced level.
REQ-014 SHALL increment the counter while synchronized value differs; on the cycle the counter equals DB_CYCLES-1 and still differs, SHALL update the debounced level and clear the counter.
REQ-015 SHALL ignore any glitch shorter than DB_CYCLES cycles, on both press and release.
REQ-016 SHALL generate a press event only on a 0->1 transition of a debounced level (release generates nothing; held button yields exactly one event).
REQ-017 SHALL push a press event into the FIFO on the clock edge following the debounced level change; entry encoding 0 = five, 1 = ten.
REQ-018 On simultaneous five and ten press events in one cycle, SHALL enqueue ten only, drop five, and set overflow.
REQ-019 On a push while FIFO full with no pop that cycle, SHALL drop the event, leave contents unchanged, set overflow.
REQ-020 On push and pop in the same cycle while full, SHALL accept the push; pending unchanged.
REQ-021 SHALL provide no bypass: an event pushed into an empty FIFO becomes poppable on the next cycle.
REQ-022 Output FSM states: IDLE, PULSE, GAP.
REQ-023 IDLE: if FIFO non-empty and ready=1, pop head, go PULSE and drive five (entry 0) or ten (entry 1) high for the PULSE cycle; else stay IDLE.
REQ-024 PULSE: outputs high exactly one cycle; unconditionally go GAP.
REQ-025 GAP: five=ten=0 for exactly one cycle; unconditionally go IDLE (pulses never in consecutive cycles; minimum spacing 3 cycles).
REQ-026 SHALL never drive five and ten high in the same cycle.
REQ-027 ready is sampled only in IDLE; deassertion during PULSE or GAP has no effect on the current pulse.
REQ-028 Latency, empty FIFO, ready=1: five/ten high in the cycle after rising edge DB_CYCLES+4, counting edge 1 as the first edge sampling raw=1.
REQ-029 pending SHALL equal pushes minus pops since reset, updated same edge as the FIFO.
REQ-030 overflow SHALL remain 1 until reset once set.

Reset
REQ-031 While rst=0, SHALL asynchronously force: synchronizers, debounced levels, counters, FIFO pointers to 0; FSM IDLE; five=0, ten=0, pending=0, overflow=0.
REQ-032 Reset mid-pulse SHALL drop the pulse immediately and discard all queued events.
REQ-033 After rst release, a button held through reset SHALL produce one press event once debounced (debounced level starts at 0).

Verification
REQ-034 Clean press: five_raw 0->1 held 20 cycles, ready=1 -> five high exactly 1 cycle, after DB_CYCLES+4 edges; ten never high; pending returns 0.
REQ-035 Bounce: ten_raw toggles 1/0 every cycle for 10 cycles then holds 1 -> exactly one ten pulse; glitch of 3 cycles (DB_CYCLES=4) -> no pulse.
REQ-036 Queue and backpressure: ready=0, five, ten, five, five presses -> pending=4, no pulses; ready=1 -> pulses five,ten,five,five in order, each 1 cycle, 2 idle cycles between.
REQ-037 Overflow: ready=0, five presses -> 4 queued, 5th dropped, overflow=1 sticky; simultaneous five+ten -> only ten queued, overflow=1.
REQ-038 Reset mid-operation: rst=0 during PULSE with pending=2 -> five/ten drop to 0 immediately, pending=0, overflow=0; no pulses after release until a new press.
